// File: rtl/bram_stream_fifo.sv
// Valid/ready FIFO controller over an external dual-port BRAM with a registered read port.
// First-word-fall-through output: a push reaches m_valid two cycles later; throughput is one word per cycle.
module bram_stream_fifo #(
  parameter int DEPTH        = 1024,
  parameter int DATA_WIDTH   = 32,
  parameter int AF_THRESHOLD = DEPTH - 4,
  localparam int ADDR_WIDTH  = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  almost_full,
  output logic                  bram_ena,
  output logic                  bram_wea,
  output logic [ADDR_WIDTH-1:0] bram_addra,
  output logic [DATA_WIDTH-1:0] bram_dia,
  output logic                  bram_enb,
  output logic [ADDR_WIDTH-1:0] bram_addrb,
  input  logic [DATA_WIDTH-1:0] bram_dob
);

  localparam logic [ADDR_WIDTH:0] FULL_LVL = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_LVL   = (ADDR_WIDTH+1)'(AF_THRESHOLD);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   level_q, level_d, pending_q, pending_d;
  logic                  m_valid_q, m_valid_d;
  logic                  s_ready_q, s_ready_d;
  logic                  almost_full_q, almost_full_d;
  logic                  push, issue, pop;

  always_comb begin
    push  = s_valid && s_ready_q && !clr;
    // A read may only be issued when the output register is free or being drained this cycle.
    issue = (pending_q != '0) && (!m_valid_q || m_ready) && !clr;
    pop   = m_valid_q && m_ready && !clr;

    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    pending_d = pending_q;
    m_valid_d = m_valid_q;

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;

    case ({push, issue})
      2'b10:   pending_d = pending_q + 1'b1;
      2'b01:   pending_d = pending_q - 1'b1;
      default: pending_d = pending_q;
    endcase

    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase

    if (issue) begin
      rd_ptr_d  = rd_ptr_q + 1'b1;
      m_valid_d = 1'b1;
    end else if (pop) begin
      m_valid_d = 1'b0;
    end

    if (clr) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      level_d   = '0;
      pending_d = '0;
      m_valid_d = 1'b0;
    end

    // The displayed word keeps its slot until popped, so level alone gates writes.
    s_ready_d     = level_d < FULL_LVL;
    almost_full_d = level_d >= AF_LVL;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      pending_q     <= '0;
      m_valid_q     <= 1'b0;
      s_ready_q     <= 1'b0;
      almost_full_q <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      level_q       <= level_d;
      pending_q     <= pending_d;
      m_valid_q     <= m_valid_d;
      s_ready_q     <= s_ready_d;
      almost_full_q <= almost_full_d;
    end
  end

  assign s_ready     = s_ready_q;
  assign m_valid     = m_valid_q;
  assign m_data      = bram_dob;
  assign level       = level_q;
  assign almost_full = almost_full_q;
  assign bram_ena    = push;
  assign bram_wea    = push;
  assign bram_addra  = wr_ptr_q;
  assign bram_dia    = s_data;
  assign bram_enb    = issue;
  assign bram_addrb  = rd_ptr_q;

endmodule
